// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - multicycle controller for the 16-bit LOAD/STORE/ADD/SUB/HALT ISA.
// Optional conditional relative jump (opcode 0110) is enabled with macro CU_JPZ_EN.
module cpu_control_unit #(
  parameter int PC_W    = 7,
  parameter int INSTR_W = 16,
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] I_data,
  input  logic               RF_Ra_zero,
  output logic [PC_W-1:0]    PC_addr,
  output logic [DADDR_W-1:0] D_addr,
  output logic               D_W_en,
  output logic               RF_s,
  output logic               RF_W_en,
  output logic [RADDR_W-1:0] RF_W_addr,
  output logic [RADDR_W-1:0] RF_Ra_addr,
  output logic [RADDR_W-1:0] RF_Rb_addr,
  output logic [2:0]         ALU_s,
  output logic [3:0]         state_o,
  output logic [15:0]        IR_o
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9,
    S_JPZ    = 4'd10
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

`ifndef CU_JPZ_EN
  logic unused_ra_zero;
  assign unused_ra_zero = RF_Ra_zero;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    D_addr     = '0;
    D_W_en     = 1'b0;
    RF_s       = 1'b0;
    RF_W_en    = 1'b0;
    RF_W_addr  = '0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s      = 3'b000;
    case (state_q)
      S_INIT:  state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = I_data;
        pc_d    = pc_q + 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (ir_q[15:12])
          4'h1:    state_d = S_STORE;
          4'h2:    state_d = S_LOAD_A;
          4'h3:    state_d = S_ADD;
          4'h4:    state_d = S_SUB;
          4'h5:    state_d = S_HALT;
`ifdef CU_JPZ_EN
          4'h6: begin
            RF_Ra_addr = ir_q[11:8];
            state_d    = S_JPZ;
          end
`endif
          default: state_d = S_NOOP;
        endcase
      end
      S_NOOP:  state_d = S_FETCH;
      S_STORE: begin
        D_addr     = ir_q[11:4];
        RF_Ra_addr = ir_q[3:0];
        D_W_en     = 1'b1;
        state_d    = S_FETCH;
      end
      S_LOAD_A, S_LOAD_B: begin
        // Two cycles so the synchronous data memory has its q ready for the write
        D_addr    = ir_q[11:4];
        RF_s      = 1'b1;
        RF_W_addr = ir_q[3:0];
        RF_W_en   = (state_q == S_LOAD_B);
        state_d   = (state_q == S_LOAD_A) ? S_LOAD_B : S_FETCH;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = ir_q[11:8];
        RF_Rb_addr = ir_q[7:4];
        RF_W_addr  = ir_q[3:0];
        ALU_s      = (state_q == S_ADD) ? 3'b001 : 3'b010;
        RF_W_en    = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
`ifdef CU_JPZ_EN
      S_JPZ: begin
        // Offset is relative to the PC already advanced during FETCH
        RF_Ra_addr = ir_q[11:8];
        if (RF_Ra_zero) pc_d = pc_q + PC_W'($signed(ir_q[7:0]));
        state_d = S_INIT;
      end
`endif
      default: state_d = S_INIT;
    endcase
  end

  assign PC_addr = pc_q;
  assign state_o = state_q;
  assign IR_o    = ir_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - directed bench for cpu_control_unit with a synchronous ROM model.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] I_data = 16'h0000;
  logic        RF_Ra_zero = 1'b0;
  logic [6:0]  PC_addr;
  logic [7:0]  D_addr;
  logic        D_W_en;
  logic        RF_s;
  logic        RF_W_en;
  logic [3:0]  RF_W_addr;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  ALU_s;
  logic [3:0]  state_o;
  logic [15:0] IR_o;

  logic [15:0] rom [0:127];
  int checks = 0;
  int errors = 0;

  cpu_control_unit dut (
    .clk(clk), .reset(reset), .I_data(I_data), .RF_Ra_zero(RF_Ra_zero),
    .PC_addr(PC_addr), .D_addr(D_addr), .D_W_en(D_W_en), .RF_s(RF_s),
    .RF_W_en(RF_W_en), .RF_W_addr(RF_W_addr), .RF_Ra_addr(RF_Ra_addr),
    .RF_Rb_addr(RF_Rb_addr), .ALU_s(ALU_s), .state_o(state_o), .IR_o(IR_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) I_data <= rom[PC_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge and confirm the two write enables are exclusive
  task automatic step();
    @(negedge clk);
    chk("we_exclusive", {31'd0, D_W_en & RF_W_en}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
  endtask

  initial begin
    clear_rom();

    // NOOP: reset state and 0,1,2,3,1
    do_reset();
    chk("rst_state", state_o, 0);
    chk("rst_pc", PC_addr, 0);
    chk("rst_ir", IR_o, 0);
    chk("rst_en", {D_W_en, RF_W_en, RF_s, ALU_s}, 0);
    chk("rst_addr", {D_addr, RF_W_addr, RF_Ra_addr, RF_Rb_addr}, 0);
    step(); chk("noop_s1", state_o, 1);
    step(); chk("noop_s2", state_o, 2);
    step(); chk("noop_s3", state_o, 3);
    step(); chk("noop_s4", state_o, 1);
    chk("noop_pc", PC_addr, 1);

    // LOAD R5 <- mem[0x05]
    rom[0] = 16'h2055;
    do_reset();
    step(); step();
    chk("ld_ir", IR_o, 16'h2055);
    step();
    chk("lda_state", state_o, 4);
    chk("lda_daddr", D_addr, 8'h05);
    chk("lda_rfs", RF_s, 1);
    chk("lda_we", RF_W_en, 0);
    step();
    chk("ldb_state", state_o, 5);
    chk("ldb_daddr", D_addr, 8'h05);
    chk("ldb_rfs", RF_s, 1);
    chk("ldb_we", RF_W_en, 1);
    chk("ldb_wa", RF_W_addr, 5);
    step();
    chk("ld_done", state_o, 1);

    // Reset during LOAD_A aborts the load
    do_reset();
    step(); step(); step();
    chk("abort_pre", state_o, 4);
    reset = 1'b1;
    step();
    chk("abort_state", state_o, 0);
    chk("abort_we", {D_W_en, RF_W_en}, 0);
    reset = 1'b0;

    // STORE mem[0xA0] <- R3
    rom[0] = 16'h1A03;
    do_reset();
    step(); step(); step();
    chk("st_state", state_o, 6);
    chk("st_dwe", D_W_en, 1);
    chk("st_daddr", D_addr, 8'hA0);
    chk("st_ra", RF_Ra_addr, 3);
    chk("st_rwe", RF_W_en, 0);
    step();
    chk("st_after_state", state_o, 1);
    chk("st_after_dwe", D_W_en, 0);

    // ADD then SUB then HALT
    rom[0] = 16'h3123; rom[1] = 16'h4124; rom[2] = 16'h5000;
    do_reset();
    step(); step(); step();
    chk("add_state", state_o, 7);
    chk("add_ports", {RF_Ra_addr, RF_Rb_addr, RF_W_addr}, 12'h123);
    chk("add_alu", ALU_s, 3'b001);
    chk("add_we", {RF_W_en, RF_s, D_W_en}, 3'b100);
    step(); step(); step();
    chk("sub_state", state_o, 8);
    chk("sub_ports", {RF_Ra_addr, RF_Rb_addr, RF_W_addr}, 12'h124);
    chk("sub_alu", ALU_s, 3'b010);
    chk("sub_we", RF_W_en, 1);
    step();
    chk("sub_next", state_o, 1);
    chk("sub_pc", PC_addr, 2);

    // HALT at ROM[1] freezes with PC=2
    clear_rom();
    rom[1] = 16'h5000;
    do_reset();
    for (int i = 0; i < 6; i++) step();
    chk("halt_enter", state_o, 9);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("halt_state", state_o, 9);
      chk("halt_pc", PC_addr, 2);
      chk("halt_en", {D_W_en, RF_W_en}, 0);
    end
    reset = 1'b1;
    step();
    chk("halt_rst_pc", PC_addr, 0);
    chk("halt_rst_state", state_o, 0);
    reset = 1'b0;

    // Opcode 0110: JPZ when enabled, NOOP otherwise
    clear_rom();
    rom[0] = 16'h61FE;
    RF_Ra_zero = 1'b1;
    do_reset();
    step(); step();
`ifdef CU_JPZ_EN
    chk("jpz_dec_ra", RF_Ra_addr, 1);
    step();
    chk("jpz_state", state_o, 10);
    step();
    chk("jpz_init", state_o, 0);
    chk("jpz_pc_taken", PC_addr, 7'h7F);
    RF_Ra_zero = 1'b0;
    do_reset();
    step(); step(); step();
    chk("jpz_state_nt", state_o, 10);
    step();
    chk("jpz_init_nt", state_o, 0);
    chk("jpz_pc_nt", PC_addr, 1);
`else
    step();
    chk("op6_noop", state_o, 3);
    step();
    chk("op6_fetch", state_o, 1);
    chk("op6_pc", PC_addr, 1);
`endif
    RF_Ra_zero = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
